bit_stuff: RTL
==============

# bit_stuff

Serial USB bit-stuffing stage between the CRC encoder and the NRZI encoder on the transmit path. It passes the packet bitstream through with one cycle of latency. After every run of STUFF_LEN consecutive 1s it inserts a 0, and it stalls the upstream stage for one cycle each time it does so. A stuff bit owed at the very end of a packet is still emitted before `sending` drops.

## Interface
- STUFF_LEN, 6: consecutive-1 run length that triggers a stuffed 0; legal range 2..7.
- clk  input  1  system clock; all state updates on posedge.
- rst_L  input  1  reset; synchronous, active-low.
- inb  input  1  upstream serial bit; valid when `recving`=1 and `stall`=0.
- recving  input  1  upstream packet-active flag; connects to the CRC encoder's `sending`.
- stall  output  1  upstream hold request; connects to the CRC encoder's `pause_out`. When 1, upstream must hold `inb` and must not advance.
- outb  output  1  registered serial output bit to the NRZI stage.
- sending  output  1  registered output-valid / packet-active flag.

## Operation
- State machine with three states:
  - IDLE: between packets.
  - PASS: forwarding bits.
  - STUFF: the next registered output is the stuffed 0.
- Registers: `state`, `ones_cnt` (3 bits), `outb`, `sending`.
- `stall` = (state==STUFF) & rst_L. It is purely combinational from state.
- IDLE or PASS with `recving`=1:
  - outb<=inb, sending<=1.
  - If inb=1: ones_cnt<=ones_cnt+1. If inb=0: ones_cnt<=0.
  - If inb=1 and ones_cnt+1==STUFF_LEN: ones_cnt<=0 and state<=STUFF.
  - Otherwise state<=PASS.
- IDLE or PASS with `recving`=0:
  - outb<=0, sending<=0, ones_cnt<=0, state<=IDLE.
- STUFF, regardless of `recving` and `inb`:
  - outb<=0, sending<=1, ones_cnt<=0, state<=PASS.
  - `inb` is not sampled.
  - The stuffed 0 counts as a 0 and restarts the run.
- Packet end:
  - If `recving` falls while in STUFF, the stuff bit is still emitted.
  - The following PASS cycle sees `recving`=0, drops `sending`, and returns to IDLE.
- Runs of 1s do not carry across packets; `ones_cnt` clears in IDLE.
- ones_cnt never exceeds STUFF_LEN-1 at a clock edge. With STUFF_LEN ≤ 7 it cannot wrap.

## Timing
- Reset: on a posedge with rst_L=0, state<=IDLE, ones_cnt<=0, outb<=0, sending<=0. `stall` is 0 while rst_L=0.
- Latency: the bit accepted at edge k appears on `outb` (with `sending`=1) in the cycle after edge k.
- Stall window:
  - `stall` is high for exactly one cycle.
  - That cycle immediately follows the edge that accepted the STUFF_LEN-th consecutive 1.
  - Upstream's presented bit during that cycle is accepted at the next edge, after the stall drops.
- Throughput: N input bits containing S stuff events produce N+S output cycles with `sending`=1, contiguous with no gaps.
- `sending` falls one edge after the last accepted bit. If a stuff is owed, it falls two edges after.
- Reset mid-STUFF: `stall` drops immediately (combinational on rst_L). At the edge, all state clears, no stuff bit is emitted, and the packet is abandoned.
- Back-to-back packets: `recving` high again in the cycle after it fell is accepted from IDLE with ones_cnt=0.

## Test plan
- Reset: hold rst_L=0 for 2 edges with recving=1, inb=1 → outb=0, sending=0, stall=0; release, then the first bit appears one cycle later.
- No stuff: stream 1,1,1,1,1,0,1 → outb 1,1,1,1,1,0,1 delayed by 1; stall never 1; sending high for exactly 7 cycles.
- Single stuff: 8 ones → outb 1,1,1,1,1,1,0,1,1; stall high for one cycle after the 6th one; upstream held bit 7 appears after the inserted 0; sending high for 9 cycles.
- Trailing stuff: packet of exactly 6 ones, recving drops with stall → outb 1×6 then 0; sending high for 7 cycles, then 0; state returns to IDLE.
- Repeated stuff: 12 ones → 0 inserted after the 6th and 12th ones (14 output cycles); verifies the stuffed 0 resets the run count.
- Reset during STUFF: assert rst_L=0 in the stall cycle of the 8-ones case → stall=0 immediately; after the edge, sending=0 and outb=0; the next packet of 6 ones stuffs correctly from a clean count.

Source files
------------

// File: rtl/bit_stuff.sv
// USB transmit bit-stuffing stage: forwards the serial stream with one cycle of
// latency and inserts a 0 after every STUFF_LEN consecutive 1s, stalling upstream.
module bit_stuff #(
  parameter int STUFF_LEN = 6
) (
  input  logic clk,
  input  logic rst_L,
  input  logic inb,
  input  logic recving,
  output logic stall,
  output logic outb,
  output logic sending
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS  = 2'd1;
  localparam logic [1:0] S_STUFF = 2'd2;

  localparam logic [2:0] RUN_LIMIT = 3'(STUFF_LEN);

  logic [1:0] state_q,    state_d;
  logic [2:0] ones_cnt_q, ones_cnt_d;
  logic       outb_q,     outb_d;
  logic       sending_q,  sending_d;
  logic [2:0] ones_inc;

  assign ones_inc = ones_cnt_q + 3'd1;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned; without this the tool would infer a latch.
    state_d    = state_q;
    ones_cnt_d = ones_cnt_q;
    outb_d     = outb_q;
    sending_d  = sending_q;

    if (state_q == S_STUFF) begin
      // The inserted 0 counts as a 0, so the run restarts; inb is not sampled.
      outb_d     = 1'b0;
      sending_d  = 1'b1;
      ones_cnt_d = 3'd0;
      state_d    = S_PASS;
    end else if (recving) begin
      outb_d    = inb;
      sending_d = 1'b1;
      state_d   = S_PASS;
      if (inb) begin
        if (ones_inc == RUN_LIMIT) begin
          ones_cnt_d = 3'd0;
          state_d    = S_STUFF;
        end else begin
          ones_cnt_d = ones_inc;
        end
      end else begin
        ones_cnt_d = 3'd0;
      end
    end else begin
      // Packet over: runs of 1s never carry into the next packet.
      outb_d     = 1'b0;
      sending_d  = 1'b0;
      ones_cnt_d = 3'd0;
      state_d    = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state_q    <= S_IDLE;
      ones_cnt_q <= 3'd0;
      outb_q     <= 1'b0;
      sending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ones_cnt_q <= ones_cnt_d;
      outb_q     <= outb_d;
      sending_q  <= sending_d;
    end
  end

  // Gated by rst_L so the hold request drops as soon as reset is asserted.
  assign stall   = (state_q == S_STUFF) & rst_L;
  assign outb    = outb_q;
  assign sending = sending_q;

endmodule
